// File: rtl/regfile_mrnw.sv
// Parametrised multi-read, multi-write register file with same-cycle bypass,
// highest-port-wins write conflicts, optional zero register and a bulk-clear engine.
module regfile_mrnw #(
    parameter int DATA_WIDTH    = 32,
    parameter int REG_FILE_SIZE = 32,
    parameter int NUM_RD        = 2,
    parameter int NUM_WR        = 2,
    parameter int BYPASS        = 1,
    parameter int ZERO_REG      = 1,
    localparam int AW           = (REG_FILE_SIZE > 1) ? $clog2(REG_FILE_SIZE) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_RD*AW-1:0]         i_raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0] o_rdata,
    input  logic [NUM_WR-1:0]            i_wen,
    input  logic [NUM_WR*AW-1:0]         i_waddr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] i_wdata,
    input  logic                         i_clr,
    output logic                         o_busy,
    output logic                         o_wr_conflict
);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [AW-1:0]         r_cnt;
    logic                  r_wr_conflict;
    logic [DATA_WIDTH-1:0] r_rf [REG_FILE_SIZE];

    logic [AW-1:0]         w_raddr [NUM_RD];
    logic [AW-1:0]         w_waddr [NUM_WR];
    logic [DATA_WIDTH-1:0] w_wdata [NUM_WR];
    logic [NUM_WR-1:0]     w_weff;
    logic                  w_conflict;
    logic                  w_busy;
    logic                  w_cnt_last;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return int'(a) < REG_FILE_SIZE;
    endfunction

    function automatic logic is_zero_reg(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign w_busy        = (r_state == CLEAR);
    assign w_cnt_last    = (int'(r_cnt) == REG_FILE_SIZE - 1);
    assign o_busy        = w_busy;
    assign o_wr_conflict = r_wr_conflict;

    always_comb begin
        for (int k = 0; k < NUM_RD; k++) w_raddr[k] = i_raddr[k*AW +: AW];
        for (int j = 0; j < NUM_WR; j++) begin
            w_waddr[j] = i_waddr[j*AW +: AW];
            w_wdata[j] = i_wdata[j*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // A write only counts (for storage, bypass and conflict) once it passes every drop rule.
    always_comb begin
        w_weff = '0;
        for (int j = 0; j < NUM_WR; j++)
            w_weff[j] = i_wen[j] && !w_busy && addr_ok(w_waddr[j]) && !is_zero_reg(w_waddr[j]);
    end

    always_comb begin
        w_conflict = 1'b0;
        for (int i = 0; i < NUM_WR; i++)
            for (int j = i + 1; j < NUM_WR; j++)
                if (w_weff[i] && w_weff[j] && (w_waddr[i] == w_waddr[j]))
                    w_conflict = 1'b1;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_clr) w_next = CLEAR;
            CLEAR:   if (w_cnt_last) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_wr_conflict <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_wr_conflict <= w_conflict;
            if (w_busy && !w_cnt_last)
                r_cnt <= r_cnt + AW'(1);
            else
                r_cnt <= '0;
        end
    end

    // Ascending port order makes the highest-indexed effective write the survivor.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_FILE_SIZE; i++) r_rf[i] <= '0;
        end else if (w_busy) begin
            r_rf[r_cnt] <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++)
                if (w_weff[j]) r_rf[w_waddr[j]] <= w_wdata[j];
        end
    end

    always_comb begin
        o_rdata = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (!w_busy && addr_ok(w_raddr[k]) && !is_zero_reg(w_raddr[k])) begin
                o_rdata[k*DATA_WIDTH +: DATA_WIDTH] = r_rf[w_raddr[k]];
                if (BYPASS != 0)
                    for (int j = 0; j < NUM_WR; j++)
                        if (w_weff[j] && (w_waddr[j] == w_raddr[k]))
                            o_rdata[k*DATA_WIDTH +: DATA_WIDTH] = w_wdata[j];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mrnw.sv
// Directed bench for regfile_mrnw: one BYPASS=1 instance under full test and a
// BYPASS=0 twin sharing its inputs for the stored-path comparison.
module tb_regfile_mrnw;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic [2*AW-1:0] i_raddr;
    logic [2*DW-1:0] o_rdata;
    logic [2*DW-1:0] o_rdata_nb;
    logic [1:0]    i_wen;
    logic [2*AW-1:0] i_waddr;
    logic [2*DW-1:0] i_wdata;
    logic          i_clr;
    logic          o_busy;
    logic          o_busy_nb;
    logic          o_wr_conflict;
    logic          o_wr_conflict_nb;

    int checks = 0;
    int errors = 0;

    regfile_mrnw u_dut (
        .clk(clk), .rst(rst), .i_raddr(i_raddr), .o_rdata(o_rdata),
        .i_wen(i_wen), .i_waddr(i_waddr), .i_wdata(i_wdata), .i_clr(i_clr),
        .o_busy(o_busy), .o_wr_conflict(o_wr_conflict)
    );

    regfile_mrnw #(.BYPASS(0)) u_nb (
        .clk(clk), .rst(rst), .i_raddr(i_raddr), .o_rdata(o_rdata_nb),
        .i_wen(i_wen), .i_waddr(i_waddr), .i_wdata(i_wdata), .i_clr(i_clr),
        .o_busy(o_busy_nb), .o_wr_conflict(o_wr_conflict_nb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        i_raddr = {a1, a0};
    endtask

    task automatic set_wr(input logic [1:0] en, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                          input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        i_wen   = en;
        i_waddr = {a1, a0};
        i_wdata = {d1, d0};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (o_busy !== 1'b0 || o_wr_conflict !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: busy=%b conflict=%b expected 0 0", o_busy, o_wr_conflict);
        end
        for (int a = 0; a < 32; a++) begin
            set_rd(AW'(a), AW'(31 - a));
            #1;
            checks++;
            if (o_rdata !== '0) begin
                errors++;
                $display("[TB] FAIL reset_read addr=%0d: got %h expected 0", a, o_rdata);
            end
        end
    endtask

    task automatic test_basic_write();
        @(negedge clk);
        set_wr(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0);
        set_rd(5'd5, 5'd5);
        @(negedge clk);
        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        #1;
        checks++;
        if (o_rdata !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
            errors++;
            $display("[TB] FAIL basic_write_r5: got %h expected %h", o_rdata, {32'hDEADBEEF, 32'hDEADBEEF});
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        set_wr(2'b10, 5'd0, 32'h0, 5'd7, 32'h1234);
        set_rd(5'd7, 5'd5);
        #1;
        checks++;
        if (o_rdata[DW-1:0] !== 32'h1234) begin
            errors++;
            $display("[TB] FAIL bypass_same_cycle: got %h expected %h", o_rdata[DW-1:0], 32'h1234);
        end
        checks++;
        if (o_rdata_nb[DW-1:0] !== 32'h0) begin
            errors++;
            $display("[TB] FAIL nobypass_same_cycle: got %h expected %h", o_rdata_nb[DW-1:0], 32'h0);
        end
        checks++;
        if (o_rdata[2*DW-1:DW] !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL bypass_other_port: got %h expected %h", o_rdata[2*DW-1:DW], 32'hDEADBEEF);
        end
        @(negedge clk);
        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        #1;
        checks++;
        if (o_rdata_nb[DW-1:0] !== 32'h1234 || o_rdata[DW-1:0] !== 32'h1234) begin
            errors++;
            $display("[TB] FAIL bypass_next_cycle: got %h / %h expected %h", o_rdata[DW-1:0], o_rdata_nb[DW-1:0], 32'h1234);
        end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        set_wr(2'b11, 5'd0, 32'hFFFFFFFF, 5'd0, 32'hFFFFFFFF);
        set_rd(5'd0, 5'd0);
        #1;
        checks++;
        if (o_rdata !== '0) begin
            errors++;
            $display("[TB] FAIL zero_reg_bypass: got %h expected 0", o_rdata);
        end
        @(negedge clk);
        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        #1;
        checks++;
        if (o_rdata !== '0 || o_wr_conflict !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_reg_stored: got %h conflict=%b expected 0 0", o_rdata, o_wr_conflict);
        end
    endtask

    task automatic test_conflict();
        @(negedge clk);
        set_wr(2'b11, 5'd9, 32'hAAAA, 5'd9, 32'hBBBB);
        set_rd(5'd9, 5'd7);
        #1;
        checks++;
        if (o_rdata[DW-1:0] !== 32'hBBBB) begin
            errors++;
            $display("[TB] FAIL conflict_bypass: got %h expected %h", o_rdata[DW-1:0], 32'hBBBB);
        end
        checks++;
        if (o_wr_conflict !== 1'b0) begin
            errors++;
            $display("[TB] FAIL conflict_early: got %b expected 0", o_wr_conflict);
        end
        @(negedge clk);
        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        set_rd(5'd9, 5'd9);
        #1;
        checks++;
        if (o_wr_conflict !== 1'b1) begin
            errors++;
            $display("[TB] FAIL conflict_pulse: got %b expected 1", o_wr_conflict);
        end
        checks++;
        if (o_rdata !== {32'hBBBB, 32'hBBBB}) begin
            errors++;
            $display("[TB] FAIL conflict_stored: got %h expected %h", o_rdata, {32'hBBBB, 32'hBBBB});
        end
        @(negedge clk);
        #1;
        checks++;
        if (o_wr_conflict !== 1'b0) begin
            errors++;
            $display("[TB] FAIL conflict_one_cycle: got %b expected 0", o_wr_conflict);
        end
        // Writes to different addresses must not flag a conflict.
        @(negedge clk);
        set_wr(2'b11, 5'd10, 32'h10, 5'd11, 32'h11);
        @(negedge clk);
        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        set_rd(5'd10, 5'd11);
        #1;
        checks++;
        if (o_wr_conflict !== 1'b0 || o_rdata !== {32'h11, 32'h10}) begin
            errors++;
            $display("[TB] FAIL no_conflict_distinct: conflict=%b data=%h expected 0 %h", o_wr_conflict, o_rdata, {32'h11, 32'h10});
        end
    endtask

    task automatic test_bulk_clear();
        int busy_cycles;
        for (int a = 1; a < 32; a++) begin
            @(negedge clk);
            set_wr(2'b01, AW'(a), DW'(a), 5'd0, 32'h0);
        end
        @(negedge clk);
        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        set_rd(5'd31, 5'd17);
        #1;
        checks++;
        if (o_rdata !== {32'd17, 32'd31}) begin
            errors++;
            $display("[TB] FAIL fill_readback: got %h expected %h", o_rdata, {32'd17, 32'd31});
        end
        i_clr = 1'b1;
        @(negedge clk);
        i_clr = 1'b0;
        busy_cycles = 0;
        for (int n = 0; n < 100 && o_busy === 1'b1; n++) begin
            busy_cycles++;
            set_rd(5'd31, AW'(n));
            #1;
            checks++;
            if (o_rdata !== '0) begin
                errors++;
                $display("[TB] FAIL read_while_busy n=%0d: got %h expected 0", n, o_rdata);
            end
            set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
            i_clr = 1'b0;
            if (busy_cycles == 10) set_wr(2'b01, 5'd3, 32'h33, 5'd0, 32'h0);
            if (busy_cycles == 20) i_clr = 1'b1;
            @(negedge clk);
        end
        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        i_clr = 1'b0;
        checks++;
        if (busy_cycles != 32) begin
            errors++;
            $display("[TB] FAIL busy_duration: got %0d expected 32", busy_cycles);
        end
        for (int a = 0; a < 32; a++) begin
            set_rd(AW'(a), AW'(a));
            #1;
            checks++;
            if (o_rdata !== '0) begin
                errors++;
                $display("[TB] FAIL after_clear addr=%0d: got %h expected 0", a, o_rdata);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        @(negedge clk);
        set_wr(2'b01, 5'd6, 32'h66, 5'd0, 32'h0);
        @(negedge clk);
        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        i_clr = 1'b1;
        @(negedge clk);
        i_clr = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_before_reset: got %b expected 1", o_busy);
        end
        #2;
        rst = 1'b1;
        #1;
        set_rd(5'd6, 5'd6);
        #1;
        checks++;
        if (o_busy !== 1'b0 || o_rdata !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid_clear: busy=%b data=%h expected 0 0", o_busy, o_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        set_wr(2'b01, 5'd4, 32'h55, 5'd0, 32'h0);
        set_rd(5'd4, 5'd6);
        @(negedge clk);
        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        #1;
        checks++;
        if (o_busy !== 1'b0 || o_rdata !== {32'h0, 32'h55}) begin
            errors++;
            $display("[TB] FAIL write_after_reset: busy=%b data=%h expected 0 %h", o_busy, o_rdata, {32'h0, 32'h55});
        end
    endtask

    initial begin
        rst     = 1'b1;
        i_clr   = 1'b0;
        i_raddr = '0;
        i_wen   = '0;
        i_waddr = '0;
        i_wdata = '0;
        test_reset();
        test_basic_write();
        test_bypass();
        test_zero_reg();
        test_conflict();
        test_bulk_clear();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mrnw.md
Name: regfile_mrnw

Overview:
- Parametrised multi-port register file; successor to the fixed two-read, one-write register file.
- Configurable read-port count, write-port count, width and depth.
- Adds same-cycle write-to-read bypass, a deterministic write-conflict policy, an optional hardwired zero register, and a sequenced bulk-clear engine.
- Sits in the core's decode/writeback path, feeding operand reads and accepting multiple writebacks per cycle.

Parameters:
- DATA_WIDTH, 32, bits per register.
- REG_FILE_SIZE, 32, number of registers; need not be a power of two. AW = $clog2(REG_FILE_SIZE).
- NUM_RD, 2, number of read ports (1..8).
- NUM_WR, 2, number of write ports (1..4).
- BYPASS, 1, 1: same-cycle write data is forwarded to matching reads. 0: reads see stored value only.
- ZERO_REG, 1, 1: register 0 reads 0 and ignores writes.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- i_raddr  in  NUM_RD*AW  read addresses; port k uses slice [k*AW +: AW].
- o_rdata  out  NUM_RD*DATA_WIDTH  read data; port k uses slice [k*DATA_WIDTH +: DATA_WIDTH].
- i_wen  in  NUM_WR  per-port write enable.
- i_waddr  in  NUM_WR*AW  write addresses.
- i_wdata  in  NUM_WR*DATA_WIDTH  write data.
- i_clr  in  1  request bulk clear (single-cycle pulse sufficient).
- o_busy  out  1  clear in progress.
- o_wr_conflict  out  1  registered pulse: two or more enabled write ports targeted the same valid address in the previous cycle.

Behaviour:
- Reset (async, rst=1):
  - all entries become 0; FSM goes to IDLE; clear counter = 0.
  - o_busy = 0; o_wr_conflict = 0.
  - o_rdata is therefore 0 for every address.
- Reads:
  - Combinational, no intentional delay.
  - Read port k returns rf[raddr_k], subject to the overrides below, applied in priority order:
    1. o_busy=1 -> 0.
    2. raddr >= REG_FILE_SIZE -> 0.
    3. ZERO_REG=1 and raddr=0 -> 0.
    4. BYPASS=1 and an effective write hits raddr this cycle -> that write's data.
- Effective write (port j): i_wen[j]=1, o_busy=0, waddr < REG_FILE_SIZE, and not (ZERO_REG=1 and waddr=0). All other writes are silently dropped.
- Write conflict:
  - Multiple effective writes to the same address in one cycle -> the highest port index wins, for both the stored value and the bypass value.
  - o_wr_conflict = 1 on the next cycle only.
  - Dropped writes never count towards a conflict.
- Write latency: an effective write at edge N is visible via the stored path from edge N onward; with BYPASS=1 it is also visible during the cycle before edge N.
- Clear FSM, states IDLE and CLEAR:
  - IDLE: i_clr=1 at posedge -> CLEAR; counter = 0; o_busy = 1 from that edge.
    - Writes presented in the same cycle as the accepting i_clr are still performed, but are overwritten by the clear.
  - CLEAR: each posedge writes 0 to rf[counter], then counter+1.
    - When counter = REG_FILE_SIZE-1 is written -> IDLE; o_busy = 0; counter = 0.
    - Duration is exactly REG_FILE_SIZE cycles of o_busy=1.
    - i_clr during CLEAR is ignored (no restart).
    - All external writes are dropped.
    - o_wr_conflict stays 0.
  - rst asserted mid-CLEAR: immediate async reset as above; the FSM does not resume.
- No X on o_rdata after reset for any in-range or out-of-range address.

Test Plan:
- Reset/basic:
  - rst pulse, then read addrs 0..31 on both ports -> all 0.
  - Write 0xDEADBEEF to r5 via port 0 -> next cycle both ports reading r5 return 0xDEADBEEF.
- Bypass:
  - BYPASS=1: in one cycle, port 1 writes 0x1234 to r7 while read port 0 addresses r7 -> o_rdata slice 0 = 0x1234 in the same cycle.
  - Repeat with BYPASS=0 -> old value 0 in that cycle, 0x1234 next cycle.
- Zero register: write 0xFFFFFFFF to r0 on both ports -> r0 reads 0 with bypass on; o_wr_conflict stays 0.
- Conflict:
  - Port 0 writes 0xAAAA and port 1 writes 0xBBBB to r9 in the same cycle.
  - Required: same-cycle bypass read = 0xBBBB; stored value = 0xBBBB; o_wr_conflict = 1 for exactly one cycle.
- Bulk clear:
  - Fill r1..r31 with their index, then pulse i_clr.
  - Required: o_busy high for exactly 32 cycles; all reads 0 while busy; a write to r3 during busy is dropped; after o_busy falls every register reads 0.
- Reset mid-clear: rst 10 cycles into CLEAR -> o_busy=0 immediately, all registers 0, FSM IDLE; a subsequent write to r4 of 0x55 is stored.
